m_mcctrl: RTL and testbench

- Multi-cycle control unit that sequences the team's MIPS-subset datapath through IF/ID/EX/MEM/WB.
- Uses a single 4K-word memory for both instruction fetch and data access, so it also arbitrates memory between fetch and load/store.
- Generates all datapath enables and selects, handles memory wait states, and keeps halt, illegal-instruction and retired-instruction status.
- Sits beside the multi-cycle datapath (PC, IR, MDR, regfile, ALU, memory).

---
 rtl/m_mcctrl_pkg.sv | 33 +++
 rtl/m_mcctrl_waitcnt.sv | 45 ++++
 rtl/m_mcctrl.sv | 214 +++++++++++++++++++++
 tb/tb_m_mcctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_mcctrl_pkg.sv
// -----------------------------------------------------------------------------
// m_mcctrl_pkg
// Shared definitions for the multi-cycle MIPS-subset controller and datapath:
// state encoding, opcode/funct constants and a small opcode-class helper.
// -----------------------------------------------------------------------------
package m_mcctrl_pkg;

    // Controller states; codes 6 and 7 are unused and recover to ST_IF.
    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4,
        ST_HLT = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2b;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_HALT   = 6'h11;
    localparam logic [5:0] FUNCT_ADD = 6'h20;

    // Opcodes that proceed from ID into EX.
    function automatic logic is_exec_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) ||
               (op == OP_SW)    || (op == OP_BEQ)  || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/m_mcctrl_waitcnt.sv
// -----------------------------------------------------------------------------
// m_waitcnt
// 4-bit loadable down-counter timing memory accesses. The controller reloads
// it on entry to IF or MEM and decrements it while the access is in progress;
// last_o marks the final cycle of the access.
// Ports:
//   clk     clock
//   rst     asynchronous active-high reset (counter returns to LOAD_VAL)
//   load_i  reload with LOAD_VAL (wins over dec_i)
//   dec_i   decrement by one
//   last_o  counter is zero
// -----------------------------------------------------------------------------
module m_waitcnt #(
    parameter logic [3:0] LOAD_VAL = 4'd0
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic last_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (dec_i) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= LOAD_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == 4'd0);

endmodule

// File: rtl/m_mcctrl.sv
// -----------------------------------------------------------------------------
// m_mcctrl
// Multi-cycle control unit for the MIPS-subset datapath. Sequences
// IF/ID/EX/MEM/WB over a single shared memory, stretching IF and MEM to
// MEM_LAT cycles, and keeps halt / illegal / retired-instruction status.
// Ports:
//   w_clk, w_rst          clock, asynchronous active-high reset
//   w_run                 run enable, sampled on the first IF cycle only
//   w_op, w_funct, w_eq   IR opcode, IR funct, datapath rs==rt compare
//   w_iord .. w_reg_we    datapath enables and selects
//   r_state               current state code
//   r_halt, r_illegal     sticky status flags
//   r_icnt                retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module m_mcctrl
    import m_mcctrl_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        w_clk,
    input  logic        w_rst,
    input  logic        w_run,
    input  logic [5:0]  w_op,
    input  logic [5:0]  w_funct,
    input  logic        w_eq,
    output logic        w_iord,
    output logic        w_ir_we,
    output logic        w_mdr_we,
    output logic        w_mem_we,
    output logic        w_pc_we,
    output logic        w_pc_src,
    output logic        w_alusrc,
    output logic        w_regdst,
    output logic        w_wbsel,
    output logic        w_reg_we,
    output logic [2:0]  r_state,
    output logic        r_halt,
    output logic        r_illegal,
    output logic [31:0] r_icnt
);

    localparam logic [3:0] LOAD_VAL = 4'(MEM_LAT - 1);

    state_t      state_q, state_d;
    logic        first_q, first_d;   // next IF cycle is the first of the fetch
    logic        halt_q, halt_d;
    logic        ill_q, ill_d;
    logic [31:0] icnt_q, icnt_d;
    logic        retire;
    logic        cnt_load, cnt_dec, cnt_last;

    m_waitcnt #(.LOAD_VAL(LOAD_VAL)) u_waitcnt (
        .clk    (w_clk),
        .rst    (w_rst),
        .load_i (cnt_load),
        .dec_i  (cnt_dec),
        .last_o (cnt_last)
    );

    always_comb begin
        state_d   = state_q;
        first_d   = first_q;
        halt_d    = halt_q;
        ill_d     = ill_q;
        icnt_d    = icnt_q;
        retire    = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        w_iord    = 1'b0;
        w_ir_we   = 1'b0;
        w_mdr_we  = 1'b0;
        w_mem_we  = 1'b0;
        w_pc_we   = 1'b0;
        w_pc_src  = 1'b0;
        w_alusrc  = 1'b0;
        w_regdst  = 1'b0;
        w_wbsel   = 1'b0;
        w_reg_we  = 1'b0;

        case (state_q)
            ST_IF: begin
                // A stalled first cycle holds everything, including the counter.
                if (!(first_q && !w_run)) begin
                    first_d = 1'b0;
                    if (cnt_last) begin
                        w_ir_we = 1'b1;
                        w_pc_we = 1'b1;
                        state_d = ST_ID;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            ST_ID: begin
                if (w_op == OP_HALT) begin
                    state_d = ST_HLT;
                    halt_d  = 1'b1;
                end else if (is_exec_op(w_op)) begin
                    state_d = ST_EX;
                end else begin
                    ill_d   = 1'b1;
                    retire  = 1'b1;
                    state_d = ST_IF;
                end
            end
            ST_EX: begin
                w_alusrc = (w_op == OP_ADDI) || (w_op == OP_LW) || (w_op == OP_SW);
                case (w_op)
                    OP_BEQ: begin
                        w_pc_we  = w_eq;
                        w_pc_src = 1'b1;
                        retire   = 1'b1;
                        state_d  = ST_IF;
                    end
                    OP_BNE: begin
                        w_pc_we  = ~w_eq;
                        w_pc_src = 1'b1;
                        retire   = 1'b1;
                        state_d  = ST_IF;
                    end
                    OP_LW, OP_SW: state_d = ST_MEM;
                    OP_ADDI:      state_d = ST_WB;
                    OP_RTYPE: begin
                        if (w_funct == FUNCT_ADD) begin
                            state_d = ST_WB;
                        end else begin
                            // Unsupported R-type: retire as a NOP without writeback.
                            ill_d   = 1'b1;
                            retire  = 1'b1;
                            state_d = ST_IF;
                        end
                    end
                    default: begin
                        retire  = 1'b1;
                        state_d = ST_IF;
                    end
                endcase
            end
            ST_MEM: begin
                w_iord = 1'b1;
                if (cnt_last) begin
                    if (w_op == OP_LW) begin
                        w_mdr_we = 1'b1;
                        state_d  = ST_WB;
                    end else begin
                        w_mem_we = (w_op == OP_SW);
                        retire   = 1'b1;
                        state_d  = ST_IF;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_WB: begin
                w_reg_we = 1'b1;
                w_regdst = (w_op == OP_RTYPE);
                w_wbsel  = (w_op == OP_LW);
                retire   = 1'b1;
                state_d  = ST_IF;
            end
            ST_HLT: begin
                // Terminal until reset.
            end
            default: state_d = ST_IF;
        endcase

        if (retire) begin
            icnt_d = icnt_q + 32'd1;
        end
        if ((state_d == ST_IF || state_d == ST_MEM) && state_d != state_q) begin
            cnt_load = 1'b1;
        end
        if (state_d == ST_IF && state_q != ST_IF) begin
            first_d = 1'b1;
        end

        // While reset is held the state register sits at IF; with MEM_LAT=1 the
        // IF decode would otherwise raise IR/PC loads during reset.
        if (w_rst) begin
            w_iord   = 1'b0;
            w_ir_we  = 1'b0;
            w_mdr_we = 1'b0;
            w_mem_we = 1'b0;
            w_pc_we  = 1'b0;
            w_pc_src = 1'b0;
            w_alusrc = 1'b0;
            w_regdst = 1'b0;
            w_wbsel  = 1'b0;
            w_reg_we = 1'b0;
        end
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            state_q <= ST_IF;
            first_q <= 1'b1;
            halt_q  <= 1'b0;
            ill_q   <= 1'b0;
            icnt_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            halt_q  <= halt_d;
            ill_q   <= ill_d;
            icnt_q  <= icnt_d;
        end
    end

    assign r_state   = state_q;
    assign r_halt    = halt_q;
    assign r_illegal = ill_q;
    assign r_icnt    = icnt_q;

endmodule

// File: tb/tb_m_mcctrl.sv
// -----------------------------------------------------------------------------
// tb_m_mcctrl
// Three controllers with MEM_LAT = 1, 2, 3 are exercised one after another.
// Each instruction is expanded into an expected per-cycle trace (phase list:
// fetch, decode, execute, memory, writeback) and the DUT is compared to it
// every cycle.
// -----------------------------------------------------------------------------
module tb_m_mcctrl;

    localparam logic [5:0] T_R    = 6'h00;
    localparam logic [5:0] T_ADDI = 6'h08;
    localparam logic [5:0] T_LW   = 6'h23;
    localparam logic [5:0] T_SW   = 6'h2b;
    localparam logic [5:0] T_BEQ  = 6'h04;
    localparam logic [5:0] T_BNE  = 6'h05;
    localparam logic [5:0] T_HALT = 6'h11;
    localparam logic [5:0] T_ADDF = 6'h20;

    // control word bit masks: {iord, ir, mdr, mem, pcwe, pcsrc, alusrc, regdst, wbsel, regwe}
    localparam logic [9:0] B_IORD   = 10'h200;
    localparam logic [9:0] B_IR     = 10'h100;
    localparam logic [9:0] B_MDR    = 10'h080;
    localparam logic [9:0] B_MEM    = 10'h040;
    localparam logic [9:0] B_PCWE   = 10'h020;
    localparam logic [9:0] B_PCSRC  = 10'h010;
    localparam logic [9:0] B_ALUSRC = 10'h008;
    localparam logic [9:0] B_REGDST = 10'h004;
    localparam logic [9:0] B_WBSEL  = 10'h002;
    localparam logic [9:0] B_REGWE  = 10'h001;

    typedef struct {
        logic        run;
        logic [2:0]  st;
        logic [9:0]  cw;
        logic [31:0] icnt;
        logic        ill;
        logic        halt;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_a    [3];
    logic        run_a    [3];
    logic        eq_a     [3];
    logic [5:0]  op_a     [3];
    logic [5:0]  funct_a  [3];
    logic        iord_a   [3];
    logic        ir_a     [3];
    logic        mdr_a    [3];
    logic        memwe_a  [3];
    logic        pcwe_a   [3];
    logic        pcsrc_a  [3];
    logic        alusrc_a [3];
    logic        regdst_a [3];
    logic        wbsel_a  [3];
    logic        regwe_a  [3];
    logic [2:0]  state_a  [3];
    logic        halt_a   [3];
    logic        ill_a    [3];
    logic [31:0] icnt_a   [3];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            m_mcctrl #(.MEM_LAT(gi + 1)) u_dut (
                .w_clk     (clk),
                .w_rst     (rst_a[gi]),
                .w_run     (run_a[gi]),
                .w_op      (op_a[gi]),
                .w_funct   (funct_a[gi]),
                .w_eq      (eq_a[gi]),
                .w_iord    (iord_a[gi]),
                .w_ir_we   (ir_a[gi]),
                .w_mdr_we  (mdr_a[gi]),
                .w_mem_we  (memwe_a[gi]),
                .w_pc_we   (pcwe_a[gi]),
                .w_pc_src  (pcsrc_a[gi]),
                .w_alusrc  (alusrc_a[gi]),
                .w_regdst  (regdst_a[gi]),
                .w_wbsel   (wbsel_a[gi]),
                .w_reg_we  (regwe_a[gi]),
                .r_state   (state_a[gi]),
                .r_halt    (halt_a[gi]),
                .r_illegal (ill_a[gi]),
                .r_icnt    (icnt_a[gi])
            );
        end
    endgenerate

    int          checks = 0;
    int          errors = 0;
    int          cur_k  = 0;
    logic [31:0] m_icnt [3];
    logic        m_ill  [3];
    logic        m_halt [3];
    ent_t        q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut=%0d observed=%0h expected=%0h", tag, cur_k, obs, exp);
        end
    endtask

    function automatic logic [9:0] obs_cw(input int k);
        return {iord_a[k], ir_a[k], mdr_a[k], memwe_a[k], pcwe_a[k],
                pcsrc_a[k], alusrc_a[k], regdst_a[k], wbsel_a[k], regwe_a[k]};
    endfunction

    // Append n cycles of one phase; the control word 'last' applies on its final cycle.
    task automatic add(input int k, input int n, input logic [2:0] st,
                       input logic [9:0] body, input logic [9:0] last, input logic run_first);
        ent_t e;
        for (int i = 0; i < n; i++) begin
            e.run  = (i == 0 && run_first) ? 1'b1 : 1'($urandom_range(0, 1));
            e.st   = st;
            e.cw   = (i == n - 1) ? last : body;
            e.icnt = m_icnt[k];
            e.ill  = m_ill[k];
            e.halt = m_halt[k];
            q.push_back(e);
        end
    endtask

    // Expected trace of one instruction for latency L = k+1.
    task automatic build(input int k, input logic [5:0] op, input logic [5:0] funct,
                         input logic eq, input int stall);
        ent_t e;
        int   lat = k + 1;
        for (int i = 0; i < stall; i++) begin
            e.run = 1'b0; e.st = 3'd0; e.cw = 10'h0;
            e.icnt = m_icnt[k]; e.ill = m_ill[k]; e.halt = m_halt[k];
            q.push_back(e);
        end
        add(k, lat, 3'd0, 10'h0, B_IR | B_PCWE, 1'b1);
        add(k, 1, 3'd1, 10'h0, 10'h0, 1'b0);
        if (op == T_HALT) begin
            m_halt[k] = 1'b1;
            add(k, 20, 3'd5, 10'h0, 10'h0, 1'b0);
            return;
        end
        case (op)
            T_BEQ: add(k, 1, 3'd2, 10'h0, B_PCSRC | (eq ? B_PCWE : 10'h0), 1'b0);
            T_BNE: add(k, 1, 3'd2, 10'h0, B_PCSRC | (eq ? 10'h0 : B_PCWE), 1'b0);
            T_ADDI: begin
                add(k, 1, 3'd2, 10'h0, B_ALUSRC, 1'b0);
                add(k, 1, 3'd4, 10'h0, B_REGWE, 1'b0);
            end
            T_LW: begin
                add(k, 1, 3'd2, 10'h0, B_ALUSRC, 1'b0);
                add(k, lat, 3'd3, B_IORD, B_IORD | B_MDR, 1'b0);
                add(k, 1, 3'd4, 10'h0, B_REGWE | B_WBSEL, 1'b0);
            end
            T_SW: begin
                add(k, 1, 3'd2, 10'h0, B_ALUSRC, 1'b0);
                add(k, lat, 3'd3, B_IORD, B_IORD | B_MEM, 1'b0);
            end
            T_R: begin
                add(k, 1, 3'd2, 10'h0, 10'h0, 1'b0);
                if (funct == T_ADDF) add(k, 1, 3'd4, 10'h0, B_REGWE | B_REGDST, 1'b0);
                else m_ill[k] = 1'b1;
            end
            default: m_ill[k] = 1'b1;
        endcase
        m_icnt[k] = m_icnt[k] + 32'd1;
    endtask

    task automatic exec(input int k, input ent_t e);
        run_a[k] = e.run;
        @(negedge clk);
        chk("state",   32'(state_a[k]), 32'(e.st));
        chk("ctrl",    32'(obs_cw(k)),  32'(e.cw));
        chk("icnt",    icnt_a[k],       e.icnt);
        chk("illegal", 32'(ill_a[k]),   32'(e.ill));
        chk("halt",    32'(halt_a[k]),  32'(e.halt));
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input int k, input logic [5:0] op, input logic [5:0] funct,
                         input logic eq, input int stall);
        op_a[k] = op; funct_a[k] = funct; eq_a[k] = eq;
        build(k, op, funct, eq, stall);
        while (q.size() > 0) exec(k, q.pop_front());
    endtask

    // Called at posedge+1; leaves the instance out of reset at posedge+1.
    task automatic do_reset(input int k);
        rst_a[k] = 1'b1;
        run_a[k] = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_state", 32'(state_a[k]), 32'd0);
        chk("rst_ctrl",  32'(obs_cw(k)),  32'd0);
        chk("rst_icnt",  icnt_a[k],       32'd0);
        chk("rst_ill",   32'(ill_a[k]),   32'd0);
        chk("rst_halt",  32'(halt_a[k]),  32'd0);
        rst_a[k]  = 1'b0;
        m_icnt[k] = 32'd0; m_ill[k] = 1'b0; m_halt[k] = 1'b0;
    endtask

    // SW abandoned by reset during its first MEM cycle.
    task automatic sw_reset(input int k);
        ent_t e;
        int   lat = k + 1;
        op_a[k] = T_SW; funct_a[k] = 6'h0; eq_a[k] = 1'b0;
        build(k, T_SW, 6'h0, 1'b0, 0);
        for (int i = 0; i < lat + 2; i++) exec(k, q.pop_front());
        e = q.pop_front();
        run_a[k] = e.run;
        #1;
        chk("mem_ctrl", 32'(obs_cw(k)), 32'(e.cw));
        rst_a[k] = 1'b1;
        #1;
        chk("arst_ctrl",  32'(obs_cw(k)),  32'd0);
        chk("arst_state", 32'(state_a[k]), 32'd0);
        chk("arst_icnt",  icnt_a[k],       32'd0);
        q.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("arst_memwe", 32'(memwe_a[k]), 32'd0);
            @(posedge clk);
        end
        #1;
        rst_a[k]  = 1'b0;
        m_icnt[k] = 32'd0; m_ill[k] = 1'b0; m_halt[k] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog dut=%0d expired", cur_k);
        $fatal(1);
    end

    initial begin
        logic [5:0] rop;
        logic [5:0] rfn;
        for (int k = 0; k < 3; k++) begin
            rst_a[k] = 1'b1; run_a[k] = 1'b0; eq_a[k] = 1'b0;
            op_a[k] = 6'h0; funct_a[k] = 6'h0;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            cur_k = k;
            do_reset(k);
            instr(k, T_ADDI, 6'h00, 1'b0, 0);
            instr(k, T_LW,   6'h00, 1'b0, 0);
            instr(k, T_BNE,  6'h00, 1'b0, 0);
            instr(k, T_BNE,  6'h00, 1'b1, 0);
            instr(k, T_R,    T_ADDF, 1'b0, 5);
            instr(k, T_BEQ,  6'h00, 1'b1, 0);
            instr(k, T_SW,   6'h00, 1'b0, 0);
            if (k == 1) sw_reset(k);
            for (int r = 0; r < 20; r++) begin
                rfn = T_ADDF;
                case ($urandom_range(0, 8))
                    0: rop = T_R;
                    1: begin
                        rop = T_R;
                        rfn = 6'($urandom_range(0, 63));
                        if (rfn == T_ADDF) rfn = 6'h21;
                    end
                    2: rop = T_ADDI;
                    3: rop = T_LW;
                    4: rop = T_SW;
                    5: rop = T_BEQ;
                    6: rop = T_BNE;
                    7: begin
                        rop = 6'($urandom_range(0, 63));
                        if (rop inside {T_R, T_ADDI, T_LW, T_SW, T_BEQ, T_BNE, T_HALT})
                            rop = 6'h3e;
                    end
                    default: rop = T_LW;
                endcase
                instr(k, rop, rfn, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
            end
            instr(k, 6'h3f, 6'h00, 1'b0, 0);
            instr(k, T_HALT, 6'h00, 1'b0, 0);
            rst_a[k] = 1'b1;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
